// File: rtl/field_packer_pkg.sv
// Shared types and helpers for the field packer.
package field_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  // Bits needed to count 0..n_fields-1; never narrower than one bit.
  function automatic int cnt_width(input int n_fields);
    return (n_fields > 1) ? $clog2(n_fields) : 1;
  endfunction

endpackage

// File: rtl/field_packer_outreg.sv
// Single-entry valid/ready holding register for the packed output word.
// FIELD_PACKER_LAST_EN adds the last flag and field count beside the data.
//
// state | meaning
// FILL  | output register empty, o_out_valid low
// FULL  | packed word held until the consumer takes it
module field_packer_outreg
  import field_packer_pkg::*;
#(
  parameter int WIDTH = 64
`ifdef FIELD_PACKER_LAST_EN
  ,
  parameter int NF_W = 3
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
`ifdef FIELD_PACKER_LAST_EN
  input  logic             load_last,
  input  logic [NF_W-1:0]  load_nfields,
  output logic             out_last,
  output logic [NF_W-1:0]  out_nfields,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  state_e state, next_state;
  logic   load;

  assign load_ready = (state == FILL) || out_ready;
  assign load       = load_valid && load_ready;
  assign out_valid  = (state == FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL;
    else        state <= next_state;
  end

  // A drain and a load in the same cycle keep the register full.
  always_comb begin
    next_state = state;
    case (state)
      FILL:    if (load) next_state = FULL;
      FULL:    if (out_ready && !load) next_state = FILL;
      default: next_state = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data    <= '0;
`ifdef FIELD_PACKER_LAST_EN
      out_last    <= 1'b0;
      out_nfields <= '0;
`endif
    end else if (load) begin
      out_data    <= load_data;
`ifdef FIELD_PACKER_LAST_EN
      out_last    <= load_last;
      out_nfields <= load_nfields;
`endif
    end
  end

endmodule

// File: rtl/field_packer.sv
// Packs N_FIELDS consecutive FIELD_W-bit fields into one word, first field in the MSBs.
// FIELD_PACKER_LAST_EN enables early flush on i_in_last with PAD_VALUE fill.
module field_packer
  import field_packer_pkg::*;
#(
  parameter int                 FIELD_W   = 16,
  parameter int                 N_FIELDS  = 4,
  parameter logic [FIELD_W-1:0] PAD_VALUE = '0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic [FIELD_W-1:0]            i_in_data,
`ifdef FIELD_PACKER_LAST_EN
  input  logic                          i_in_last,
  output logic                          o_out_last,
  output logic [$clog2(N_FIELDS+1)-1:0] o_out_nfields,
`endif
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [N_FIELDS*FIELD_W-1:0]   o_out_data
);

  localparam int               CNT_W    = cnt_width(N_FIELDS);
  localparam int               OUT_W    = N_FIELDS * FIELD_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FIELDS - 1);
`ifdef FIELD_PACKER_LAST_EN
  localparam int               NF_W     = $clog2(N_FIELDS + 1);
`endif

  logic [CNT_W-1:0]   count;
  logic [FIELD_W-1:0] acc [N_FIELDS];
  logic               completes;
  logic               accept;
  logic               out_load_ready;
  logic [OUT_W-1:0]   packed_word;

`ifdef FIELD_PACKER_LAST_EN
  assign completes = (count == LAST_IDX) || i_in_last;
`else
  assign completes = (count == LAST_IDX);
`endif

  // Only a completing field can stall, and only while the output is held.
  assign o_in_ready = !completes || out_load_ready;
  assign accept     = i_in_valid && o_in_ready;

  // Earlier fields from the accumulator, the current field live, padding below it.
  always_comb begin
    packed_word = '0;
    for (int j = 0; j < N_FIELDS; j++) begin
      if (j < int'(count))
        packed_word[OUT_W-1-j*FIELD_W -: FIELD_W] = acc[j];
      else if (j == int'(count))
        packed_word[OUT_W-1-j*FIELD_W -: FIELD_W] = i_in_data;
      else
        packed_word[OUT_W-1-j*FIELD_W -: FIELD_W] = PAD_VALUE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count <= '0;
      for (int j = 0; j < N_FIELDS; j++) acc[j] <= '0;
    end else if (accept) begin
      if (completes) begin
        count <= '0;
        for (int j = 0; j < N_FIELDS; j++) acc[j] <= '0;
      end else begin
        count      <= count + CNT_W'(1);
        acc[count] <= i_in_data;
      end
    end
  end

  field_packer_outreg #(
    .WIDTH (OUT_W)
`ifdef FIELD_PACKER_LAST_EN
    ,
    .NF_W  (NF_W)
`endif
  ) u_outreg (
    .clk          (i_clk),
    .rst_n        (i_rst_n),
    .load_valid   (i_in_valid && completes),
    .load_ready   (out_load_ready),
    .load_data    (packed_word),
`ifdef FIELD_PACKER_LAST_EN
    .load_last    (i_in_last),
    .load_nfields (NF_W'(count) + NF_W'(1)),
    .out_last     (o_out_last),
    .out_nfields  (o_out_nfields),
`endif
    .out_valid    (o_out_valid),
    .out_ready    (i_out_ready),
    .out_data     (o_out_data)
  );

endmodule

// File: tb/tb_field_packer.sv
// Scoreboard bench for field_packer: reference packer model feeds an expected-word queue.
module tb_field_packer;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int OW = N * W;
  localparam logic [W-1:0] PAD = '0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
`ifdef FIELD_PACKER_LAST_EN
  logic          out_last;
  logic [2:0]    out_nfields;
`endif

  always #5 clk = ~clk;

  field_packer #(.FIELD_W(W), .N_FIELDS(N), .PAD_VALUE(PAD)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_data     (in_data),
`ifdef FIELD_PACKER_LAST_EN
    .i_in_last     (in_last),
    .o_out_last    (out_last),
    .o_out_nfields (out_nfields),
`endif
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_data    (out_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int words_seen = 0;

  logic [W-1:0]  mfields[$];
  logic [OW-1:0] exp_q[$];
  int            exp_nf_q[$];
  bit            exp_last_q[$];
  bit            mvalid = 1'b0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: fields collected in order, word = first field in MSBs, padded below.
  always @(negedge clk) begin
    bit completes, exp_rdy, acc;
    logic [OW-1:0] word;
    if (!rst_n) begin
      mfields.delete();
      exp_q.delete();
      exp_nf_q.delete();
      exp_last_q.delete();
      mvalid = 1'b0;
    end else begin
      completes = (mfields.size() == N - 1);
`ifdef FIELD_PACKER_LAST_EN
      completes = completes || in_last;
`endif
      exp_rdy = !(completes && mvalid && !out_ready);
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, mvalid);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
`ifdef FIELD_PACKER_LAST_EN
          check("out_nfields", out_nfields, exp_nf_q.pop_front());
          check("out_last", out_last, exp_last_q.pop_front());
`endif
          words_seen++;
        end
      end
      acc = in_valid && exp_rdy;
      if (acc) begin
        mfields.push_back(in_data);
        if (completes) begin
          word = '0;
          for (int i = 0; i < N; i++)
            word = (word << W) | OW'((i < mfields.size()) ? mfields[i] : PAD);
          exp_q.push_back(word);
          exp_nf_q.push_back(mfields.size());
          exp_last_q.push_back(in_last);
          mfields.delete();
        end
      end
      mvalid = (acc && completes) ? 1'b1 : (out_ready ? 1'b0 : mvalid);
    end
  end

  task automatic cycle(input bit v, input logic [W-1:0] d, input bit ordy, input bit last,
                       output bit acc);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    in_last   = last;
    @(negedge clk);
    acc = v && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input bit ordy, input bit last);
    bit a = 1'b0;
    int n = 0;
    while (!a && n < 50) begin
      cycle(1'b1, d, ordy, last, a);
      n++;
    end
    if (!a) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept for %h", d);
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int base;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'hdead; out_ready = 1'b1; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;

    // Four fields, one word, one cycle latency
    send(16'h1111, 1'b1, 1'b0);
    send(16'h2222, 1'b1, 1'b0);
    send(16'h3333, 1'b1, 1'b0);
    send(16'h4444, 1'b1, 1'b0);
    check("t2_valid", out_valid, 1);
    check("t2_data", out_data, 64'h1111_2222_3333_4444);
    idle(2);

    // Backpressure: word held, 8th field stalls until drain
    for (int i = 1; i <= 7; i++) send(W'(i), 1'b0, 1'b0);
    check("t3_held_valid", out_valid, 1);
    check("t3_held_data", out_data, 64'h0001_0002_0003_0004);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'h0008, 1'b0, 1'b0, a);
      check("t3_stall", a, 0);
    end
    send(16'h0008, 1'b1, 1'b0);
    check("t3_second", out_data, 64'h0005_0006_0007_0008);
    idle(2);

    // Sustained throughput
    base = words_seen;
    for (int i = 0; i < 64; i++) send(W'(i + 16'h100), 1'b1, 1'b0);
    idle(2);
    check("t4_words", words_seen - base, 16);

    // Reset mid-word discards partial fields
    send(16'h0bad, 1'b1, 1'b0);
    send(16'h0bad, 1'b1, 1'b0);
    rst_n = 1'b0;
    cycle(1'b0, '0, 1'b1, 1'b0, a);
    rst_n = 1'b1;
    base = words_seen;
    send(16'h000a, 1'b1, 1'b0);
    send(16'h000b, 1'b1, 1'b0);
    send(16'h000c, 1'b1, 1'b0);
    send(16'h000d, 1'b1, 1'b0);
    check("t5_data", out_data, 64'h000a_000b_000c_000d);
    idle(2);
    check("t5_words", words_seen - base, 1);

`ifdef FIELD_PACKER_LAST_EN
    send(16'haaaa, 1'b1, 1'b0);
    send(16'hbbbb, 1'b1, 1'b1);
    check("t6_data", out_data, 64'haaaa_bbbb_0000_0000);
    check("t6_nfields", out_nfields, 2);
    check("t6_last", out_last, 1);
    idle(2);
`endif

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      bit lst;
      lst = 1'b0;
`ifdef FIELD_PACKER_LAST_EN
      lst = ($urandom_range(0, 9) == 0);
`endif
      cycle($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 9) < 6, lst, a);
    end
    idle(3);
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
